seg_scan_controller: RTL and testbench

//  Time-multiplexes NUM_DIGITS BCD digits onto a single shared bcd_7seg_decoder and

---
 rtl/seg_scan_controller_if.sv | 24 ++
 rtl/seg_scan_controller.sv | 111 +++++++++++
 tb/tb_seg_scan_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_controller_if.sv
// Bus for the multiplexed 7-segment scan controller: staging load in,
// decoder code and digit enables out. Clock and reset stay plain ports.
interface seg_scan_controller_if #(
  parameter int NUM_DIGITS = 3
);
  logic                    i_load;
  logic [4*NUM_DIGITS-1:0] i_digits_in;
  logic [NUM_DIGITS-1:0]   i_blank_in;
  logic [3:0]              o_bcd;
  logic [NUM_DIGITS-1:0]   o_digit_sel;
  logic                    o_frame_start;
  logic                    o_update_done;
  logic                    o_pending;

  modport master (
    output i_load, i_digits_in, i_blank_in,
    input  o_bcd, o_digit_sel, o_frame_start, o_update_done, o_pending
  );

  modport slave (
    input  i_load, i_digits_in, i_blank_in,
    output o_bcd, o_digit_sel, o_frame_start, o_update_done, o_pending
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed BCD digit scanner with frame-boundary double buffering
// and a dark guard interval at the start of every digit slot.
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 3,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_controller_if.slave  bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {PH_GUARD, PH_DRIVE} phase_t;
  localparam phase_t START_PHASE = (GUARD_CYCLES > 0) ? PH_GUARD : PH_DRIVE;

  // Slot position and phase describe the cycle the outputs are being registered for.
  phase_t                  r_phase;
  logic [IDX_W-1:0]        r_slotIdx;
  logic [CNT_W-1:0]        r_slotCnt;
  logic [4*NUM_DIGITS-1:0] r_stgDigits;
  logic [NUM_DIGITS-1:0]   r_stgBlank;
  logic [4*NUM_DIGITS-1:0] r_actDigits;
  logic [NUM_DIGITS-1:0]   r_actBlank;
  logic                    r_pending;

  logic                    w_frameEdge;
  logic                    w_commit;
  logic [4*NUM_DIGITS-1:0] w_effDigits;
  logic [NUM_DIGITS-1:0]   w_effBlank;
  logic [3:0]              w_code;
  logic                    w_blankBit;
  logic                    w_dark;
  logic [NUM_DIGITS-1:0]   w_oneHot;
  logic [CNT_W-1:0]        w_cntInc;

  // On a commit edge the staging set is forwarded so slot 0 shows new data at once.
  always_comb begin
    w_frameEdge = (r_slotIdx == '0) && (r_slotCnt == '0);
    w_commit    = w_frameEdge && r_pending;
    w_effDigits = w_commit ? r_stgDigits : r_actDigits;
    w_effBlank  = w_commit ? r_stgBlank : r_actBlank;
    w_cntInc    = r_slotCnt + 1'b1;
    w_code      = 4'd0;
    w_blankBit  = 1'b1;
    w_oneHot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_slotIdx == IDX_W'(k)) begin
        w_code      = w_effDigits[4*k +: 4];
        w_blankBit  = w_effBlank[k];
        w_oneHot[k] = 1'b1;
      end
    end
    w_dark = w_blankBit || (w_code > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase           <= START_PHASE;
      r_slotIdx         <= '0;
      r_slotCnt         <= '0;
      r_stgDigits       <= '0;
      r_stgBlank        <= '1;
      r_actDigits       <= '0;
      r_actBlank        <= '1;
      r_pending         <= 1'b0;
      bus.o_bcd         <= 4'd0;
      bus.o_digit_sel   <= '0;
      bus.o_frame_start <= 1'b0;
      bus.o_update_done <= 1'b0;
    end else begin
      bus.o_frame_start <= w_frameEdge;
      bus.o_update_done <= w_commit;
      bus.o_bcd         <= w_dark ? 4'd0 : w_code;
      bus.o_digit_sel   <= ((r_phase == PH_DRIVE) && !w_dark) ? w_oneHot : '0;

      if (w_commit) begin
        r_actDigits <= r_stgDigits;
        r_actBlank  <= r_stgBlank;
      end

      // A load on the commit edge lands after the commit and stays pending.
      if (bus.i_load) begin
        r_stgDigits <= bus.i_digits_in;
        r_stgBlank  <= bus.i_blank_in;
        r_pending   <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end

      if (r_slotCnt == LAST_CNT) begin
        r_slotCnt <= '0;
        r_slotIdx <= (r_slotIdx == LAST_IDX) ? '0 : r_slotIdx + 1'b1;
        r_phase   <= START_PHASE;
      end else begin
        r_slotCnt <= w_cntInc;
        if (w_cntInc == GUARD_END) begin
          r_phase <= PH_DRIVE;
        end
      end
    end
  end

  assign bus.o_pending = r_pending;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: the stimulus side predicts each
// frame's contents, the monitor checks every cycle of each frame it sees.
module tb_seg_scan_controller;

  localparam int ND = 3;
  localparam int SD = 8;
  localparam int GC = 2;
  localparam int FL = ND * SD;

  typedef struct packed {
    logic [11:0] digits;
    logic [2:0]  blank;
    logic        ud;
    logic        pend;
  } frameRec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_controller #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          vectorCount = 0;
  int          missCount   = 0;
  int          pushed      = 0;
  int          popped      = 0;
  bit          monEn       = 1'b0;
  frameRec_t   expQ[$];

  logic [11:0] stgD;
  logic [11:0] actD;
  logic [2:0]  stgB;
  logic [2:0]  actB;
  bit          pend;
  int          curPos;

  task automatic checkOutput(input string name, input int t, input logic [31:0] got,
                             input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s t=%0d got=%0h exp=%0h", name, t, got, exp);
    end
  endtask

  // Monitor: every frame_start pops one predicted frame and checks all its cycles.
  initial begin : monitor
    frameRec_t   rec;
    int          offset;
    bit          inFrame;
    int          slot;
    logic [3:0]  dig;
    bit          dark;
    logic [2:0]  expSel;
    logic [3:0]  expBcd;
    inFrame = 1'b0;
    offset  = 0;
    rec     = '0;
    forever begin
      @(negedge clk);
      if (!monEn) begin
        inFrame = 1'b0;
        continue;
      end
      if (bus.o_frame_start) begin
        if (inFrame) checkOutput("frameLength", offset, 32'(offset + 1), 32'(FL));
        if (expQ.size() == 0) begin
          vectorCount++;
          missCount++;
          $display("[TB] FAIL expQueue got=empty exp=frame record at frame_start");
          inFrame = 1'b0;
          continue;
        end
        rec     = expQ.pop_front();
        popped++;
        inFrame = 1'b1;
        offset  = 0;
        checkOutput("updateDone", 0, 32'(bus.o_update_done), 32'(rec.ud));
        checkOutput("pendingAtF", 0, 32'(bus.o_pending), 32'(rec.pend));
      end else if (inFrame) begin
        offset++;
        if (offset >= FL) begin
          vectorCount++;
          missCount++;
          $display("[TB] FAIL frameStart got=0 exp=1 t=%0d", offset);
          inFrame = 1'b0;
          continue;
        end
        checkOutput("updateDoneIdle", offset, 32'(bus.o_update_done), 32'(0));
      end
      if (inFrame) begin
        slot   = offset / SD;
        dig    = rec.digits[4*slot +: 4];
        dark   = rec.blank[slot] || (dig > 4'd9);
        expSel = (!dark && (offset % SD) >= GC) ? (3'b001 << slot) : 3'b000;
        expBcd = dark ? 4'd0 : dig;
        checkOutput("digitSel", offset, 32'(bus.o_digit_sel), 32'(expSel));
        checkOutput("bcd", offset, 32'(bus.o_bcd), 32'(expBcd));
      end
    end
  end

  // One input cycle; the last cycle of a frame also predicts the next frame.
  task automatic doCycle(input bit ld, input logic [11:0] d, input logic [2:0] b);
    frameRec_t rec;
    bus.i_load      = ld;
    bus.i_digits_in = d;
    bus.i_blank_in  = b;
    if (curPos == FL - 1) begin
      rec.ud = pend;
      if (pend) begin
        actD = stgD;
        actB = stgB;
        pend = 1'b0;
      end
      if (ld) begin
        stgD = d;
        stgB = b;
        pend = 1'b1;
      end
      rec.digits = actD;
      rec.blank  = actB;
      rec.pend   = pend;
      expQ.push_back(rec);
      pushed++;
    end else if (ld) begin
      stgD = d;
      stgB = b;
      pend = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.i_load = 1'b0;
    curPos = (curPos + 1) % FL;
  endtask

  task automatic applyStimulus(input int posA, input logic [11:0] dA, input logic [2:0] bA,
                               input int posB, input logic [11:0] dB, input logic [2:0] bB);
    for (int p = 0; p < FL; p++) begin
      if (p == posA)      doCycle(1'b1, dA, bA);
      else if (p == posB) doCycle(1'b1, dB, bB);
      else                doCycle(1'b0, 12'($urandom), 3'($urandom));
    end
  endtask

  // Holds reset (with loads that must be ignored), then releases into frame cycle F.
  task automatic resetSequence(input int cycles);
    frameRec_t rec;
    monEn           = 1'b0;
    rst             = 1'b1;
    bus.i_load      = 1'b1;
    bus.i_digits_in = 12'h987;
    bus.i_blank_in  = 3'b000;
    expQ.delete();
    repeat (cycles) begin
      @(posedge clk);
      #1;
      checkOutput("rstDigitSel", 0, 32'(bus.o_digit_sel), 32'(0));
      checkOutput("rstBcd", 0, 32'(bus.o_bcd), 32'(0));
      checkOutput("rstFrameStart", 0, 32'(bus.o_frame_start), 32'(0));
      checkOutput("rstUpdateDone", 0, 32'(bus.o_update_done), 32'(0));
      checkOutput("rstPending", 0, 32'(bus.o_pending), 32'(0));
    end
    bus.i_load = 1'b0;
    stgD = '0;
    actD = '0;
    stgB = '1;
    actB = '1;
    pend = 1'b0;
    rec  = '{digits: 12'h000, blank: 3'b111, ud: 1'b0, pend: 1'b0};
    expQ.push_back(rec);
    pushed++;
    rst   = 1'b0;
    monEn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("frameStartAfterRelease", 0, 32'(bus.o_frame_start), 32'(1));
    curPos = 0;
  endtask

  initial begin : stimulus
    int posA;
    int posB;
    bus.i_load      = 1'b0;
    bus.i_digits_in = '0;
    bus.i_blank_in  = '0;
    curPos          = 0;

    resetSequence(3);
    applyStimulus(-1, 12'h000, 3'b000, -1, 12'h000, 3'b000);
    applyStimulus(10, 12'h173, 3'b000, -1, 12'h000, 3'b000);
    applyStimulus(3, 12'h123, 3'b000, 15, 12'h456, 3'b000);
    applyStimulus(5, 12'h95C, 3'b010, -1, 12'h000, 3'b000);
    applyStimulus(FL - 1, 12'h802, 3'b000, -1, 12'h000, 3'b000);
    applyStimulus(-1, 12'h000, 3'b000, -1, 12'h000, 3'b000);
    applyStimulus(4, 12'h333, 3'b000, FL - 1, 12'h222, 3'b000);
    applyStimulus(-1, 12'h000, 3'b000, -1, 12'h000, 3'b000);

    for (int f = 0; f < 10; f++) begin
      posA = int'($urandom_range(0, 30));
      posB = int'($urandom_range(0, 30));
      applyStimulus(posA, 12'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
                    posB, 12'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000);
    end

    // Reset in the middle of slot 1 of a running frame.
    for (int p = 0; p < 13; p++) doCycle(1'b0, 12'($urandom), 3'($urandom));
    resetSequence(2);
    applyStimulus(7, 12'h543, 3'b000, -1, 12'h000, 3'b000);
    applyStimulus(-1, 12'h000, 3'b000, -1, 12'h000, 3'b000);

    repeat (FL) begin
      @(posedge clk);
      #1;
    end
    monEn = 1'b0;
    checkOutput("scoreboardDrain", 0, 32'(popped), 32'(pushed));

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
